num_storage_bank_ram: RTL and testbench
=======================================

// Module: num_storage_bank_ram
// PURPOSE
// - Multi-bank successor to the single-bank number store. Holds converted integers from the ASCII number separator.
// - Adds per-bank append/addressed writes, fill counters, non-blocking per-bank clear, and a read-valid strobe.
// - Sits between the separator (writer) and the matrix loader (reader), e.g. one bank per operand matrix.
// PARAMETERS
// - DATA_WIDTH  32    word width
// - DEPTH       2048  words per bank, >=2, need not be a power of 2
// - NUM_BANKS   2     independent banks, >=1
// - ADDR_WIDTH  $clog2(DEPTH)           derived, do not override
// - BANK_WIDTH  max(1,$clog2(NUM_BANKS)) derived
// - CNT_WIDTH   $clog2(DEPTH+1)         derived
// PORTS
// - clk          in   1                       clock, all logic on posedge
// - rst_n        in   1                       async active-low reset
// - clear_req    in   1                       1-cycle request to clear bank clear_bank
// - clear_bank   in   BANK_WIDTH              bank to clear
// - clear_busy   out  NUM_BANKS               per-bank clearing in progress
// - wr_en        in   1                       write strobe
// - wr_bank      in   BANK_WIDTH              target bank
// - wr_append    in   1                       1: write at fill pointer; 0: write at wr_addr
// - wr_addr      in   ADDR_WIDTH              address for addressed writes
// - wr_data      in   DATA_WIDTH              write data
// - wr_err       out  1                       1-cycle pulse: write dropped
// - rd_en        in   1                       read strobe
// - rd_bank      in   BANK_WIDTH              read bank
// - rd_addr      in   ADDR_WIDTH              read address
// - rd_valid     out  1                       rd_data valid
// - rd_data      out  DATA_WIDTH              read data
// - fill_count   out  NUM_BANKS*CNT_WIDTH     per-bank fill level, bank b at [b*CNT_WIDTH +: CNT_WIDTH]
// BEHAVIOUR
// - Reset: clear_busy=0, wr_err=0, rd_valid=0, rd_data=0, all fill_count=0. Memory contents are not reset.
// - Reset mid-clear aborts the clear; contents are unspecified; fill_count is still 0.
// - Per-bank FSM: IDLE -> CLEAR on an accepted clear_req. CLEAR walks addresses 0..DEPTH-1, writing 0, one word/cycle.
// - CLEAR -> IDLE after the DEPTH-1 write, so clear_busy is high for exactly DEPTH cycles.
// - fill_count of a bank goes to 0 in the cycle after clear_req is accepted.
// - clear_req to a bank already in CLEAR, or with clear_bank>=NUM_BANKS, is ignored. Other banks keep running.
// - Write rules, registered on the clk edge:
//   - Append: address = fill_count; then fill_count+1.
//   - Addressed: address = wr_addr; fill_count = max(fill_count, wr_addr+1).
// - Write drop conditions: target bank clearing; clear_req for the same bank in the same cycle (clear wins);
//   append with fill_count==DEPTH; wr_addr>=DEPTH; wr_bank>=NUM_BANKS.
// - A dropped write leaves memory and fill_count unchanged. wr_err pulses high the cycle after the drop.
// - Read: latency 1. rd_en at cycle N gives rd_valid=1 and rd_data at N+1. rd_valid=0 when rd_en=0; rd_data holds.
// - Reads of a clearing bank, rd_addr>=DEPTH, or rd_bank>=NUM_BANKS return 0 with rd_valid=1.
// - Read/write same bank+address same cycle: read returns OLD data (read-first).
// - Arithmetic is unsigned; fill_count saturates at DEPTH and never wraps.
// CONFIGURATION
// - NUM_RAM_OUT_REG_EN defined: extra output register stage. Read latency 2; rd_valid/rd_data shift together;
//   reset value 0 for both stages.
// - NUM_RAM_OUT_REG_EN undefined: read latency 1 as above.
// - All other behaviour is identical in both builds.
// TESTING (DEPTH=8, NUM_BANKS=2, DATA_WIDTH=32, macro off unless stated)
// - Append 5,6,7 to bank0; read addr 0..2 -> 5,6,7 with rd_valid 1 cycle after each rd_en; fill_count[0]=3, [1]=0.
// - Append 9 words to bank1 -> 9th dropped, wr_err pulse once, fill_count[1]=8; addressed write addr 3 = 0xAA -> readback 0xAA.
// - Fill bank0, clear_req bank0 -> clear_busy[0] high 8 cycles, fill_count[0]=0 next cycle.
//   Writes to bank0 during clear -> wr_err; bank1 write/read unaffected; after clear, reads of 0..7 = 0.
// - Same cycle: clear_req bank0 + write bank0 -> write dropped, wr_err=1. Same-cycle read/write addr 2 -> old value, new value next read.
// - Assert rst_n=0 mid-clear at cycle 4 -> all outputs 0 immediately; after release, clear_busy=0 and append starts at addr 0.
// - Macro on: rd_en at cycle N -> rd_valid at N+2 with correct data; back-to-back reads stream one per cycle.

Source files
------------

// File: rtl/num_storage_bank_ram.sv
// num_storage_bank_ram
// Multi-bank store for the integers produced by the ASCII number separator
// and consumed by the matrix loader. Each bank has its own fill counter,
// supports append or addressed writes, and has a non-blocking clear engine
// that zeroes the bank one word per cycle. Reads are read-first with a
// registered read path.
//
// Build option: define NUM_RAM_OUT_REG_EN to add a second output register
// stage (read latency 2 instead of 1).
module num_storage_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2048,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_req,
    input  logic [BANK_WIDTH-1:0]          clear_bank,
    output logic [NUM_BANKS-1:0]           clear_busy,
    input  logic                           wr_en,
    input  logic [BANK_WIDTH-1:0]          wr_bank,
    input  logic                           wr_append,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_err,
    input  logic                           rd_en,
    input  logic [BANK_WIDTH-1:0]          rd_bank,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_BANKS*CNT_WIDTH-1:0] fill_count
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam logic [31:0]           DEPTH_U   = DEPTH;
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Shared request decode
    logic                  wr_addr_ok;
    logic                  rd_addr_ok;
    logic [CNT_WIDTH-1:0]  wr_end;

    assign wr_addr_ok = 32'(wr_addr) < DEPTH_U;
    assign rd_addr_ok = 32'(rd_addr) < DEPTH_U;
    // wr_addr+1 only matters for in-range addresses, so it always fits CNT_WIDTH
    assign wr_end     = CNT_WIDTH'(wr_addr) + CNT_WIDTH'(1);

    // Per-bank handshake with the shared read/write logic
    logic [NUM_BANKS-1:0]  clr_acc;
    logic [NUM_BANKS-1:0]  wr_acc;
    logic [NUM_BANKS-1:0]  rd_hit;
    logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        clr_state_t            state_q;
        clr_state_t            state_d;
        logic                  busy;
        logic [ADDR_WIDTH-1:0] clr_addr_q;
        logic [CNT_WIDTH-1:0]  fill_q;
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  sel_wr;
        logic                  sel_clr;
        logic                  full;
        logic [ADDR_WIDTH-1:0] wr_ptr;
        logic                  mem_we;
        logic [ADDR_WIDTH-1:0] mem_waddr;
        logic [DATA_WIDTH-1:0] mem_wdata;

        assign sel_wr  = (wr_bank == BANK_WIDTH'(b));
        assign sel_clr = clear_req && (clear_bank == BANK_WIDTH'(b));
        assign full    = (fill_q == FULL_CNT);
        assign wr_ptr  = ADDR_WIDTH'(fill_q);

        // A clear request to a bank already clearing is ignored
        assign clr_acc[b] = sel_clr && (state_q == ST_IDLE);

        // Clear in the same cycle beats a write to the same bank
        assign wr_acc[b]  = wr_en && sel_wr && !busy && !sel_clr &&
                            (wr_append ? !full : wr_addr_ok);

        assign rd_hit[b]  = rd_en && (rd_bank == BANK_WIDTH'(b)) &&
                            rd_addr_ok && !busy;

        // Clear FSM state and walk address
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_IDLE;
                clr_addr_q <= '0;
            end else begin
                state_q <= state_d;
                if (state_q == ST_CLEAR) begin
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                end else begin
                    clr_addr_q <= '0;
                end
            end
        end

        // Clear FSM next state: walk 0..DEPTH-1 then return to idle
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                ST_IDLE:  if (clr_acc[b]) state_d = ST_CLEAR;
                ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
            endcase
        end

        // Clear FSM outputs
        always_comb begin
            busy = (state_q == ST_CLEAR);
        end

        assign clear_busy[b] = busy;

        // Fill level: zeroed by an accepted clear, grown by accepted writes
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fill_q <= '0;
            end else if (clr_acc[b]) begin
                fill_q <= '0;
            end else if (wr_acc[b]) begin
                if (wr_append) begin
                    fill_q <= fill_q + CNT_WIDTH'(1);
                end else if (wr_end > fill_q) begin
                    fill_q <= wr_end;
                end
            end
        end

        assign fill_count[b*CNT_WIDTH +: CNT_WIDTH] = fill_q;

        // Single write port: the clear walk owns it while clearing, since
        // user writes to a clearing bank are always dropped
        always_comb begin
            mem_we    = 1'b0;
            mem_waddr = '0;
            mem_wdata = '0;
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
            end else if (wr_acc[b]) begin
                mem_we    = 1'b1;
                mem_waddr = wr_append ? wr_ptr : wr_addr;
                mem_wdata = wr_data;
            end
        end

        // Storage array: read-first, read register updates only on a hit
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
            if (rd_hit[b]) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign bank_q[b] = rd_q;
    end

    // Write drop flag, one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !(|wr_acc);
        end
    end

    // First read stage: remember which bank answered, or that the answer is 0
    logic                  rd_valid_s1;
    logic                  rd_zero_s1;
    logic [BANK_WIDTH-1:0] rd_sel_s1;
    logic [DATA_WIDTH-1:0] rd_data_s1;

    // Read qualifiers; rd_data holds its value while rd_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_s1 <= 1'b0;
            rd_zero_s1  <= 1'b1;
            rd_sel_s1   <= '0;
        end else begin
            rd_valid_s1 <= rd_en;
            if (rd_en) begin
                rd_zero_s1 <= !(|rd_hit);
                rd_sel_s1  <= rd_bank;
            end
        end
    end

    // Select the answering bank; misses, clearing banks and reset give 0
    always_comb begin
        rd_data_s1 = '0;
        if (!rd_zero_s1) begin
            rd_data_s1 = bank_q[rd_sel_s1];
        end
    end

`ifdef NUM_RAM_OUT_REG_EN
    // Optional output stage: valid and data move together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_valid_s1;
            rd_data  <= rd_data_s1;
        end
    end
`else
    assign rd_valid = rd_valid_s1;
    assign rd_data  = rd_data_s1;
`endif

endmodule

// File: tb/tb_num_storage_bank_ram.sv
// Directed testbench for num_storage_bank_ram (DEPTH=8, NUM_BANKS=2).
module tb_num_storage_bank_ram;

`ifdef NUM_RAM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear_req;
    logic [0:0]  clear_bank;
    logic [1:0]  clear_busy;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic        wr_append;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_err;
    logic        rd_en;
    logic [0:0]  rd_bank;
    logic [2:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [7:0]  fill_count;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles = 0;

    num_storage_bank_ram #(
        .DATA_WIDTH(32),
        .DEPTH(8),
        .NUM_BANKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear_req(clear_req),
        .clear_bank(clear_bank),
        .clear_busy(clear_busy),
        .wr_en(wr_en),
        .wr_bank(wr_bank),
        .wr_append(wr_append),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_err(wr_err),
        .rd_en(rd_en),
        .rd_bank(rd_bank),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .fill_count(fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clear_busy[0]) busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fill(input int b);
        return 32'(fill_count[b*4 +: 4]);
    endfunction

    task automatic do_write(input logic [0:0] bank, input logic app, input logic [2:0] addr,
                            input logic [31:0] data, input logic exp_err, input string tag);
        wr_en     = 1'b1;
        wr_bank   = bank;
        wr_append = app;
        wr_addr   = addr;
        wr_data   = data;
        tick();
        wr_en = 1'b0;
        check(tag, 32'(wr_err), 32'(exp_err));
    endtask

    task automatic do_read(input logic [0:0] bank, input logic [2:0] addr,
                           input logic [31:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_bank = bank;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        if (RD_LAT == 2) tick();
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, rd_data, exp);
    endtask

    task automatic wait_clear_done(input string tag);
        int n;
        n = 0;
        while (clear_busy[0] && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(clear_busy[0]), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        clear_req  = 1'b0;
        clear_bank = '0;
        wr_en      = 1'b0;
        wr_bank    = '0;
        wr_append  = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_bank    = '0;
        rd_addr    = '0;
        tick();
        tick();
        check("rst_busy",  32'(clear_busy), 32'd0);
        check("rst_wrerr", 32'(wr_err), 32'd0);
        check("rst_rdv",   32'(rd_valid), 32'd0);
        check("rst_rdd",   rd_data, 32'd0);
        check("rst_fill",  32'(fill_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Append 5,6,7 to bank0 and read back
        do_write(1'b0, 1'b1, 3'd0, 32'd5, 1'b0, "app5");
        do_write(1'b0, 1'b1, 3'd0, 32'd6, 1'b0, "app6");
        do_write(1'b0, 1'b1, 3'd0, 32'd7, 1'b0, "app7");
        check("fill0_3", fill(0), 32'd3);
        check("fill1_0", fill(1), 32'd0);
        do_read(1'b0, 3'd0, 32'd5, "rd0_0");
        do_read(1'b0, 3'd1, 32'd6, "rd0_1");
        do_read(1'b0, 3'd2, 32'd7, "rd0_2");
        tick();
        check("rdv_idle", 32'(rd_valid), 32'd0);
        check("rdd_hold", rd_data, 32'd7);

        // Overfill bank1: 9th append dropped
        for (int i = 0; i < 9; i++) begin
            do_write(1'b1, 1'b1, 3'd0, 32'(100 + i), (i == 8), $sformatf("app1_%0d", i));
        end
        tick();
        check("wrerr_pulse", 32'(wr_err), 32'd0);
        check("fill1_full", fill(1), 32'd8);
        do_write(1'b1, 1'b0, 3'd3, 32'hAA, 1'b0, "adw1_3");
        check("fill1_sat", fill(1), 32'd8);
        do_read(1'b1, 3'd3, 32'hAA, "rd1_3");
        do_read(1'b1, 3'd7, 32'd107, "rd1_7");

        // Addressed write beyond fill raises fill to addr+1
        do_write(1'b0, 1'b0, 3'd6, 32'h66, 1'b0, "adw0_6");
        check("fill0_7", fill(0), 32'd7);
        do_write(1'b0, 1'b1, 3'd0, 32'h77, 1'b0, "app0_7");
        check("fill0_8", fill(0), 32'd8);
        do_read(1'b0, 3'd6, 32'h66, "rd0_6");
        do_read(1'b0, 3'd7, 32'h77, "rd0_7");

        // Clear bank0 while bank1 keeps working
        busy_cycles = 0;
        clear_req  = 1'b1;
        clear_bank = 1'b0;
        tick();
        clear_req = 1'b0;
        check("clr_busy0", 32'(clear_busy), 32'd1);
        check("clr_fill0", fill(0), 32'd0);
        do_write(1'b0, 1'b1, 3'd0, 32'h55, 1'b1, "clr_wr0");
        do_write(1'b1, 1'b0, 3'd0, 32'h11, 1'b0, "clr_wr1");
        do_read(1'b1, 3'd0, 32'h11, "clr_rd1");
        do_read(1'b0, 3'd1, 32'd0, "clr_rd0");
        wait_clear_done("clr");
        check("clr_cycles", 32'(busy_cycles), 32'd8);
        check("clr_fill0_after", fill(0), 32'd0);
        check("clr_fill1_after", fill(1), 32'd8);
        for (int a = 0; a < 8; a++) begin
            do_read(1'b0, 3'(a), 32'd0, $sformatf("clr_rd0_%0d", a));
        end

        // Same-cycle clear and write to bank0: clear wins
        do_write(1'b0, 1'b1, 3'd0, 32'h21, 1'b0, "app0_21");
        check("fill0_1", fill(0), 32'd1);
        clear_req  = 1'b1;
        clear_bank = 1'b0;
        do_write(1'b0, 1'b1, 3'd0, 32'h22, 1'b1, "clrwr_err");
        clear_req = 1'b0;
        check("clrwr_busy", 32'(clear_busy), 32'd1);
        check("clrwr_fill", fill(0), 32'd0);
        wait_clear_done("clrwr");
        do_read(1'b0, 3'd0, 32'd0, "clrwr_rd");

        // Same-cycle read and write of bank1 addr 2: read-first
        rd_en     = 1'b1;
        rd_bank   = 1'b1;
        rd_addr   = 3'd2;
        wr_en     = 1'b1;
        wr_bank   = 1'b1;
        wr_append = 1'b0;
        wr_addr   = 3'd2;
        wr_data   = 32'hBEEF;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (RD_LAT == 2) tick();
        check("rf_old", rd_data, 32'd102);
        do_read(1'b1, 3'd2, 32'hBEEF, "rf_new");

        // Back-to-back reads stream one word per cycle
        tick();
        for (int i = 0; i < 3 + RD_LAT; i++) begin
            int k;
            if (i < 3) begin
                rd_en   = 1'b1;
                rd_bank = 1'b1;
                rd_addr = 3'(4 + i);
            end else begin
                rd_en = 1'b0;
            end
            tick();
            k = i - (RD_LAT - 1);
            if (k >= 0 && k < 3) begin
                check($sformatf("strm_v%0d", i), 32'(rd_valid), 32'd1);
                check($sformatf("strm_d%0d", i), rd_data, 32'(104 + k));
            end else begin
                check($sformatf("strm_v%0d", i), 32'(rd_valid), 32'd0);
            end
        end
        rd_en = 1'b0;

        // Reset in the middle of a clear
        do_read(1'b1, 3'd2, 32'hBEEF, "pre_rst_rd");
        do_write(1'b0, 1'b1, 3'd0, 32'h31, 1'b0, "pre_rst_app");
        clear_req  = 1'b1;
        clear_bank = 1'b0;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", 32'(clear_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_busy",  32'(clear_busy), 32'd0);
        check("mrst_wrerr", 32'(wr_err), 32'd0);
        check("mrst_rdv",   32'(rd_valid), 32'd0);
        check("mrst_rdd",   rd_data, 32'd0);
        check("mrst_fill",  32'(fill_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_busy", 32'(clear_busy), 32'd0);
        do_write(1'b0, 1'b1, 3'd0, 32'h44, 1'b0, "post_app");
        check("post_fill0", fill(0), 32'd1);
        check("post_fill1", fill(1), 32'd0);
        do_read(1'b0, 3'd0, 32'h44, "post_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
